// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder controller. A single one-bit full-add slice is applied to
// two WIDTH-bit operands, one bit per clock, LSB first. The final sum and
// carry-out are registered and announced with a one-cycle done pulse.
// This replaces a WIDTH-bit parallel adder with a single slice, trading
// latency for area.
//
// Parameters
//   WIDTH   operand/sum width in bits (1..64)
//
// Ports
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   request, accepted only while ready=1
//   A, B    in   operands, captured on the accepting edge only
//   ready   out  high in IDLE and DONE (start will be accepted)
//   busy    out  high while the serial add is running
//   done    out  one-cycle pulse: Sum/Carry have just been updated
//   Sum     out  registered (A+B) mod 2^WIDTH of the last completed add
//   Carry   out  registered carry-out of the last completed add
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // Each status output maps onto exactly one state bit ({done, busy, ready}),
   // so the outputs are straight flop outputs and cannot glitch.
   typedef enum logic [2:0] {
      IDLE = 3'b001,
      RUN  = 3'b010,
      DONE = 3'b101
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sacc_q, sacc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_q, c_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // One-bit full-add slice built from two half adders.
   logic             ha1_s, ha1_c, ha2_s, ha2_c, c_out;
   logic [WIDTH-1:0] sacc_shift;

   assign ha1_s = sa_q[0] ^ sb_q[0];
   assign ha1_c = sa_q[0] & sb_q[0];
   assign ha2_s = ha1_s ^ c_q;
   assign ha2_c = ha1_s & c_q;
   assign c_out = ha1_c | ha2_c;

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
   // Written as shift/or so it also covers WIDTH=1 without a special case.
   assign sacc_shift = (sacc_q >> 1) | (WIDTH'(ha2_s) << (WIDTH - 1));

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sacc_d  = sacc_q;
      sum_d   = sum_q;
      c_d     = c_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               sa_d    = A;
               sb_d    = B;
               c_d     = 1'b0;
               cnt_d   = '0;
               sacc_d  = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // start is deliberately not looked at here: requests during a
            // run are dropped, not queued.
            sa_d   = sa_q >> 1;
            sb_d   = sb_q >> 1;
            c_d    = c_out;
            sacc_d = sacc_shift;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               sum_d   = sacc_shift;
               carry_d = c_out;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sacc_q  <= '0;
         sum_q   <= '0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sacc_q  <= sacc_d;
         sum_q   <= sum_d;
         c_q     <= c_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready = state_q[0];
   assign busy  = state_q[1];
   assign done  = state_q[2];
   assign Sum   = sum_q;
   assign Carry = carry_q;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller. It sequences a single one-bit full-add slice over two WIDTH-bit operands, one bit per clock, LSB first, and delivers the registered sum and carry-out with a start/done handshake. The slice is two half adders with an OR on their carries. The block sits between operand registers and any consumer that trades latency for area, replacing a WIDTH-bit parallel adder.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled on clk, accepted only while ready=1.
- A  input  WIDTH  operand A; captured on the accepting edge only.
- B  input  WIDTH  operand B; captured on the accepting edge only.
- ready  output  1  high in IDLE and DONE: the block can accept start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse: Sum/Carry just updated.
- Sum  output  WIDTH  result register (A+B) mod 2^WIDTH.
- Carry  output  1  carry-out of the last add.

## Operation
- States: IDLE, RUN, DONE. Encoding is free; no unreachable-state lockup, and any illegal encoding returns to IDLE.
- Internal state:
  - shift registers sa and sb (WIDTH bits each);
  - accumulator sacc (WIDTH bits);
  - carry flop c;
  - bit counter cnt, width clog2(WIDTH+1).
- IDLE or DONE with start=1:
  - sa<=A, sb<=B, c<=0, cnt<=0, sacc<=0;
  - go to RUN.
- DONE with start=0: go to IDLE.
- IDLE with start=0: stay in IDLE.
- RUN, each edge:
  - s = sa[0]^sb[0]^c (half adder 1 on sa[0],sb[0]; half adder 2 on its sum and c).
  - c <= (sa[0]&sb[0]) | (c&(sa[0]^sb[0])).
  - sa, sb shift right by one (zero fill).
  - sacc <= {s, sacc[WIDTH-1:1]}.
  - cnt <= cnt+1.
- RUN, edge on which cnt==WIDTH-1 (last bit):
  - Sum <= final shifted sacc, including this bit's s.
  - Carry <= carry-out of this bit.
  - go to DONE.
- Sum and Carry change only on that completion edge. They hold the previous result throughout RUN and indefinitely afterwards.
- start while in RUN is ignored: not queued, no effect on the operation in progress.
- A and B may change freely after the accepting edge.
- done = (state==DONE), registered. ready = IDLE|DONE. busy = RUN. All are glitch-free decodes of registered state.

## Timing
- Reset values (async assert, any time):
  - state IDLE, Sum=0, Carry=0, done=0, busy=0, ready=1;
  - internal sa, sb, sacc, c, cnt all 0.
- Reset deassertion needs no special handling beyond async assert / sync use.
- Latency: start accepted on edge k gives busy=1 after edges k..k+WIDTH-1. Sum/Carry are valid and done=1 after edge k+WIDTH. done falls after edge k+WIDTH+1 unless a new start is accepted there, in which case busy rises instead.
- Throughput: one add per WIDTH+1 cycles when start is held high continuously (back-to-back through DONE). No idle cycle between DONE and the next RUN.
- WIDTH=1: RUN lasts exactly one cycle.
- Reset asserted mid-RUN: the operation is aborted, outputs go to their reset values, and no done pulse follows deassertion.
- Reset asserted in DONE: done drops immediately (asynchronous).

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, start pulse at edge k -> busy high for 8 cycles; done exactly one cycle after edge k+8; Sum=0x96, Carry=0; ready low during RUN.
- A=0xFF, B=0x01 -> Sum=0x00, Carry=1 (full carry ripple across all 8 serial bits). Then A=0xFF, B=0xFF -> Sum=0xFE, Carry=1. Then A=0x00, B=0x00 -> Sum=0x00, Carry=0 (carry flop correctly cleared on load).
- Start 0x12+0x34; drive start=1 with A=0xFF, B=0xFF at cycles k+2..k+5; change A/B mid-run -> result still Sum=0x46, Carry=0; exactly one done pulse; no second operation starts until ready.
- start held high continuously for 3 ops with new operands each DONE cycle -> done pulses 9 cycles apart. Sum holds the previous result during each RUN and updates only on completion edges.
- Assert rst_n low at cycle k+4 of a run, release 2 cycles later -> Sum=0, Carry=0, ready=1, no done pulse; a new start then completes normally.
- Re-run the first and second scenarios with WIDTH=1 (1+1 -> Sum=0, Carry=1; RUN one cycle). Re-run them with WIDTH=16 (0xFFFF+0x0001 -> Sum=0x0000, Carry=1; done 16 cycles after the accepting edge).
